// File: rtl/nebula_wb_pkg.sv
// Shared Wishbone types and constants for the nebula manager ports.
package nebula_wb_pkg;

    localparam int unsigned WB_ADDR_W          = 32;
    localparam int unsigned WB_DATA_W          = 32;
    localparam int unsigned WB_SEL_W           = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    localparam logic [WB_DATA_W-1:0] RSP_ERR_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } wb_state_e;

    typedef struct packed {
        logic                 we;
        logic [WB_SEL_W-1:0]  sel;
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
    } wb_req_t;

    // A request that cannot be issued as a single aligned word access.
    function automatic logic req_is_bad(input logic [WB_ADDR_W-1:0] adr,
                                        input logic [WB_SEL_W-1:0]  sel);
        return (adr[1:0] != 2'b00) || (sel == '0);
    endfunction

endpackage

// File: rtl/wishbone_manager_if.sv
// Requester handshake plus Wishbone manager bus of one wishbone_manager port.
interface wishbone_manager_if;
    import nebula_wb_pkg::*;

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [WB_ADDR_W-1:0] req_adr_i;
    logic [WB_DATA_W-1:0] req_dat_i;
    logic [WB_SEL_W-1:0]  req_sel_i;

    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [WB_DATA_W-1:0] rsp_dat_o;
    logic                 rsp_err_o;

    logic                 wbm_cyc_o;
    logic                 wbm_stb_o;
    logic                 wbm_we_o;
    logic [WB_SEL_W-1:0]  wbm_sel_o;
    logic [WB_ADDR_W-1:0] wbm_adr_o;
    logic [WB_DATA_W-1:0] wbm_dat_o;
    logic                 wbm_ack_i;
    logic [WB_DATA_W-1:0] wbm_dat_i;

    modport master (
        input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        input  rsp_ready_i, wbm_ack_i, wbm_dat_i,
        output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
        output rsp_ready_i, wbm_ack_i, wbm_dat_i,
        input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wishbone_manager.sv
// Single-outstanding Wishbone classic initiator with alignment check and
// ACK timeout, bridging a valid/ready request/response port onto the bus.
module wishbone_manager
    import nebula_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wishbone_manager_if.master bus,
    output logic               busy_o
);

    wb_state_e            state_q, state_d;
    wb_req_t              req_q, req_d;
    logic                 cyc_q, cyc_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [WB_DATA_W-1:0] rsp_dat_q, rsp_dat_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     cnt_inc;

    // State and registered outputs; reset drops CYC/STB immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cyc_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cyc_q       <= cyc_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cyc_d       = cyc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i && ready_q) begin
                    req_d.we  = bus.req_we_i;
                    req_d.sel = bus.req_sel_i;
                    req_d.adr = bus.req_adr_i;
                    req_d.dat = bus.req_dat_i;
                    cnt_d     = '0;
                    if (req_is_bad(bus.req_adr_i, bus.req_sel_i)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_dat_d   = RSP_ERR_DATA;
                    end else begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                    end
                end
            end
            BUS: begin
                cnt_d = cnt_inc;
                // ACK takes priority over a timeout expiring on the same edge.
                if (bus.wbm_ack_i) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = req_q.we ? '0 : bus.wbm_dat_i;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = RSP_ERR_DATA;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign bus.req_ready_o = ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.wbm_cyc_o   = cyc_q;
    assign bus.wbm_stb_o   = cyc_q;
    assign bus.wbm_we_o    = req_q.we;
    assign bus.wbm_sel_o   = req_q.sel;
    assign bus.wbm_adr_o   = req_q.adr;
    assign bus.wbm_dat_o   = req_q.dat;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_wishbone_manager.sv
// Bench for wishbone_manager: directed cases then random transactions
// checked against an outcome model of the request/ACK/timeout rules.
module tb_wishbone_manager;
    import nebula_wb_pkg::*;

    localparam int unsigned T = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_checks = 0;
    int   n_pass   = 0;

    wishbone_manager_if bus();

    wishbone_manager #(
        .TIMEOUT_CYCLES(T),
        .CNT_W         (16)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outcome of one request: STB-cycle count, error flag and returned data.
    function automatic void model(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                  input int ack_at, input logic [31:0] rdata,
                                  output int cycles, output logic err, output logic [31:0] dat);
        if (adr[1:0] != 2'b00 || sel == 4'h0) begin
            cycles = 0; err = 1'b1; dat = 32'h0;
        end else if (ack_at >= 1 && ack_at <= int'(T)) begin
            cycles = ack_at; err = 1'b0; dat = we ? 32'h0 : rdata;
        end else begin
            cycles = int'(T); err = 1'b1; dat = 32'h0;
        end
    endfunction

    // ack_at: STB cycle on which the responder ACKs (0 = never).
    task automatic do_txn(input string name, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input int ack_at,
                          input logic [31:0] rdata, input int stall);
        int          exp_cycles;
        int          lat;
        int          stb_cycles;
        logic        exp_err;
        logic [31:0] exp_dat;
        model(we, adr, sel, ack_at, rdata, exp_cycles, exp_err, exp_dat);

        check({name, "/ready_idle"}, 64'(bus.req_ready_o), 64'(1));
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_adr_i   = adr;
        bus.req_dat_i   = dat;
        bus.req_sel_i   = sel;
        bus.rsp_ready_i = 1'b0;
        tick();
        bus.req_valid_i = 1'b0;
        bus.req_adr_i   = $urandom;
        bus.req_dat_i   = $urandom;
        lat        = 1;
        stb_cycles = 0;
        while (!bus.rsp_valid_o && lat < 40) begin
            check({name, "/stb_eq_cyc"}, 64'(bus.wbm_stb_o), 64'(bus.wbm_cyc_o));
            if (bus.wbm_cyc_o) begin
                stb_cycles++;
                check({name, "/bus_ctl"}, 64'({bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o}),
                      64'({we, sel, adr}));
                check({name, "/bus_dat"}, 64'(bus.wbm_dat_o), 64'(dat));
                check({name, "/ready_bus"}, 64'(bus.req_ready_o), 64'(0));
                check({name, "/busy_bus"}, 64'(busy), 64'(1));
                bus.wbm_ack_i = (stb_cycles == ack_at);
                bus.wbm_dat_i = (stb_cycles == ack_at) ? rdata : $urandom;
            end else begin
                bus.wbm_ack_i = 1'b0;
            end
            tick();
            lat++;
        end
        bus.wbm_ack_i = 1'b0;
        check({name, "/rsp_valid"}, 64'(bus.rsp_valid_o), 64'(1));
        check({name, "/latency"}, 64'(lat), 64'(exp_cycles + 1));
        check({name, "/stb_cycles"}, 64'(stb_cycles), 64'(exp_cycles));
        check({name, "/rsp_err"}, 64'(bus.rsp_err_o), 64'(exp_err));
        check({name, "/rsp_dat"}, 64'(bus.rsp_dat_o), 64'(exp_dat));
        check({name, "/cyc_resp"}, 64'({bus.wbm_cyc_o, bus.wbm_stb_o}), 64'(0));

        for (int i = 0; i < stall; i++) begin
            bus.wbm_ack_i = 1'b1;
            bus.wbm_dat_i = $urandom;
            tick();
            check({name, "/hold_rsp"}, 64'({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o}),
                  64'({1'b1, exp_err, exp_dat}));
            check({name, "/hold_bus"}, 64'({bus.wbm_cyc_o, bus.req_ready_o}), 64'(0));
        end
        bus.wbm_ack_i   = 1'b0;
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        check({name, "/after_rsp"}, 64'({bus.rsp_valid_o, bus.wbm_cyc_o, busy}), 64'(0));
        check({name, "/ready_again"}, 64'(bus.req_ready_o), 64'(1));
    endtask

    initial begin
        logic        r_we;
        logic [31:0] r_adr;
        logic [3:0]  r_sel;

        rst             = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_adr_i   = '0;
        bus.req_dat_i   = '0;
        bus.req_sel_i   = '0;
        bus.rsp_ready_i = 1'b0;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_dat_i   = '0;
        tick();
        check("reset/bus_ctl", 64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}), 64'(0));
        check("reset/bus_adr", 64'(bus.wbm_adr_o), 64'(0));
        check("reset/bus_dat", 64'(bus.wbm_dat_o), 64'(0));
        check("reset/rsp", 64'({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o}), 64'(0));
        check("reset/busy", 64'(busy), 64'(0));
        rst = 1'b0;
        tick();
        check("reset/ready", 64'(bus.req_ready_o), 64'(1));

        do_txn("read_ack1", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 32'hA5A5_1234, 0);
        do_txn("write_ack3", 1'b1, 32'h3000_0004, 32'hCAFE_F00D, 4'b0011, 3, 32'h1111_2222, 0);
        do_txn("misaligned", 1'b0, 32'h3000_0002, 32'h0, 4'hF, 1, 32'h5555_5555, 0);
        do_txn("sel_zero", 1'b1, 32'h3000_0008, 32'h1234_5678, 4'h0, 1, 32'h5555_5555, 0);
        do_txn("timeout", 1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 0);
        do_txn("ack_at_limit", 1'b0, 32'h3000_0024, 32'h0, 4'hF, int'(T), 32'h0BAD_F00D, 0);
        do_txn("backpressure", 1'b0, 32'h3000_0028, 32'h0, 4'hC, 2, 32'h7777_8888, 5);

        // Reset asserted in the middle of a bus cycle.
        check("rst_mid/ready", 64'(bus.req_ready_o), 64'(1));
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_adr_i   = 32'h3000_0030;
        bus.req_sel_i   = 4'hF;
        tick();
        bus.req_valid_i = 1'b0;
        check("rst_mid/cyc_on", 64'({bus.wbm_cyc_o, bus.wbm_stb_o}), 64'(3));
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid/cyc_off", 64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, busy}), 64'(0));
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid/idle", 64'({bus.req_ready_o, busy, bus.wbm_cyc_o, bus.rsp_valid_o}), 64'(8));

        for (int n = 0; n < 40; n++) begin
            r_we  = 1'($urandom_range(0, 1));
            r_adr = $urandom;
            if ($urandom_range(0, 3) != 0) r_adr[1:0] = 2'b00;
            r_sel = 4'($urandom_range(0, 15));
            do_txn($sformatf("rand%0d", n), r_we, r_adr, $urandom, r_sel,
                   int'($urandom_range(0, 6)), $urandom, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
